// File: rtl/hull_fifo.sv
// Single-clock show-ahead FIFO. TYPE 1 keeps storage in a synchronous-read RAM and
// bypasses freshly written data so that q timing matches the flop-array variant.
module hull_fifo #(
    parameter int TYPE      = 0,
    parameter int WIDTH     = 64,
    parameter int LOG_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wrreq,
    input  logic [WIDTH-1:0] data,
    output logic             full,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    input  logic             rdreq
);

    localparam int                 DEPTH = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] CAP_C = {1'b1, {LOG_DEPTH{1'b0}}};

    logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH:0]   count_q, count_d;
    logic                 empty_s, full_s, wr_acc_s, rd_acc_s;
    logic [WIDTH-1:0]     head_s;

    // Acceptance decisions use the flags as they stand before the edge.
    always_comb begin
        empty_s  = (count_q == {(LOG_DEPTH+1){1'b0}});
        full_s   = (count_q == CAP_C);
        wr_acc_s = wrreq & ~full_s;
        rd_acc_s = rdreq & ~empty_s;
        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + LOG_DEPTH'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + LOG_DEPTH'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + (LOG_DEPTH+1)'(1);
            2'b01:   count_d = count_q - (LOG_DEPTH+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= {LOG_DEPTH{1'b0}};
            wr_ptr_q <= {LOG_DEPTH{1'b0}};
            count_q  <= {(LOG_DEPTH+1){1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    if (TYPE == 1) begin : g_ram
        logic [WIDTH-1:0] ram [DEPTH];
        logic [WIDTH-1:0] ram_rd_q;
        logic             byp_sel_q, byp_sel_d;
        logic [WIDTH-1:0] byp_data_q, byp_data_d;

        // The RAM is read at the next head address; if that slot is being
        // written this same edge the read returns stale data, so take the bypass.
        always_comb begin
            byp_sel_d  = wr_acc_s & (rd_ptr_d == wr_ptr_q);
            byp_data_d = data;
        end

        // Storage array with synchronous read of the upcoming head.
        always_ff @(posedge clock) begin
            if (wr_acc_s) begin
                ram[wr_ptr_q] <= data;
            end
            ram_rd_q <= ram[rd_ptr_d];
        end

        // Bypass register for write-to-next-head collisions.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                byp_sel_q  <= 1'b0;
                byp_data_q <= {WIDTH{1'b0}};
            end else begin
                byp_sel_q  <= byp_sel_d;
                byp_data_q <= byp_data_d;
            end
        end

        assign head_s = byp_sel_q ? byp_data_q : ram_rd_q;
    end else begin : g_flop
        logic [WIDTH-1:0] mem [DEPTH];

        // Flop storage; head is read combinationally from the read pointer.
        always_ff @(posedge clock) begin
            if (wr_acc_s) begin
                mem[wr_ptr_q] <= data;
            end
        end

        assign head_s = mem[rd_ptr_q];
    end

    assign empty = empty_s;
    assign full  = full_s;
    assign q     = empty_s ? {WIDTH{1'b0}} : head_s;

endmodule

// File: tb/tb_hull_fifo.sv
// Bench for hull_fifo: four instances (TYPE 0/1 at depth 8 and depth 4) share stimulus
// and are compared each cycle against queue-based reference models.
module tb_hull_fifo;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        wrreq = 1'b0;
    logic        rdreq = 1'b0;
    logic [63:0] data = 64'd0;

    logic [63:0] q_s     [4];
    logic        empty_s [4];
    logic        full_s  [4];

    logic [63:0] m8 [$];
    logic [63:0] m4 [$];

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        hull_fifo #(.TYPE(g % 2), .WIDTH(64), .LOG_DEPTH((g < 2) ? 3 : 2)) u_dut (
            .clock   (clock),
            .reset_n (reset_n),
            .wrreq   (wrreq),
            .data    (data),
            .full    (full_s[g]),
            .q       (q_s[g]),
            .empty   (empty_s[g]),
            .rdreq   (rdreq)
        );
    end

    // Expected {empty, full, q} of instance k from the reference queues.
    function automatic logic [65:0] exp_obs(int k);
        int          cap;
        int          sz;
        logic [63:0] head;
        cap  = (k < 2) ? 8 : 4;
        sz   = (k < 2) ? m8.size() : m4.size();
        head = 64'd0;
        if (sz > 0) head = (k < 2) ? m8[0] : m4[0];
        return {sz == 0, sz == cap, head};
    endfunction

    // One rising edge: apply the FIFO rules to the reference queues, then move to the falling edge.
    task automatic step();
        bit w8, r8, w4, r4;
        @(posedge clock);
        if (!reset_n) begin
            m8.delete();
            m4.delete();
        end else begin
            w8 = wrreq && (m8.size() < 8);
            r8 = rdreq && (m8.size() > 0);
            w4 = wrreq && (m4.size() < 4);
            r4 = rdreq && (m4.size() > 0);
            if (r8) void'(m8.pop_front());
            if (w8) m8.push_back(data);
            if (r4) void'(m4.pop_front());
            if (w4) m4.push_back(data);
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        wrreq   = 1'b0;
        rdreq   = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({empty_s[k], full_s[k], q_s[k]} !== {1'b1, 1'b0, 64'd0}) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: got %h want %h", k, {empty_s[k], full_s[k], q_s[k]}, {1'b1, 1'b0, 64'd0});
            end
        end
        for (int i = 0; i < 3; i++) begin
            wrreq = 1'b1;
            data  = 64'h30 + 64'(i);
            step();
        end
        wrreq = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        m8.delete();
        m4.delete();
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({empty_s[k], full_s[k], q_s[k]} !== {1'b1, 1'b0, 64'd0}) begin
                miscompares++;
                $display("FAIL async_reset dut%0d: got %h want %h", k, {empty_s[k], full_s[k], q_s[k]}, {1'b1, 1'b0, 64'd0});
            end
        end
        @(negedge clock);
        reset_n = 1'b1;
        wrreq   = 1'b1;
        data    = 64'hA5;
        step();
        wrreq = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({empty_s[k], full_s[k], q_s[k]} !== {1'b0, 1'b0, 64'hA5}) begin
                miscompares++;
                $display("FAIL post_reset_write dut%0d: got %h want %h", k, {empty_s[k], full_s[k], q_s[k]}, {1'b0, 1'b0, 64'hA5});
            end
        end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            wrreq = 1'b1;
            data  = (i == 8) ? 64'hFF : 64'(i);
            step();
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if ({empty_s[k], full_s[k], q_s[k]} !== exp_obs(k)) begin
                    miscompares++;
                    $display("FAIL fill[%0d] dut%0d: got %h want %h", i, k, {empty_s[k], full_s[k], q_s[k]}, exp_obs(k));
                end
            end
        end
        wrreq = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if ({empty_s[k], q_s[k]} !== {1'b0, 64'(i)}) begin
                    miscompares++;
                    $display("FAIL drain_order[%0d] dut%0d: got %h want %h", i, k, {empty_s[k], q_s[k]}, {1'b0, 64'(i)});
                end
            end
            rdreq = 1'b1;
            step();
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if ({empty_s[k], full_s[k], q_s[k]} !== exp_obs(k)) begin
                    miscompares++;
                    $display("FAIL drain[%0d] dut%0d: got %h want %h", i, k, {empty_s[k], full_s[k], q_s[k]}, exp_obs(k));
                end
            end
        end
        rdreq = 1'b0;
    endtask

    task automatic test_show_ahead();
        do_reset();
        wrreq = 1'b1;
        data  = 64'h11;
        step();
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({empty_s[k], q_s[k]} !== {1'b0, 64'h11}) begin
                miscompares++;
                $display("FAIL show_ahead_first dut%0d: got %h want %h", k, {empty_s[k], q_s[k]}, {1'b0, 64'h11});
            end
        end
        data = 64'h22;
        step();
        wrreq = 1'b0;
        rdreq = 1'b1;
        step();
        rdreq = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({empty_s[k], q_s[k]} !== {1'b0, 64'h22}) begin
                miscompares++;
                $display("FAIL show_ahead_next dut%0d: got %h want %h", k, {empty_s[k], q_s[k]}, {1'b0, 64'h22});
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        wrreq = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data = 64'hA0 + 64'(i);
            step();
        end
        rdreq = 1'b1;
        data  = 64'hBEEF;
        step();
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({empty_s[k], full_s[k], q_s[k]} !== exp_obs(k)) begin
                miscompares++;
                $display("FAIL rw_full dut%0d: got %h want %h", k, {empty_s[k], full_s[k], q_s[k]}, exp_obs(k));
            end
        end
        wrreq = 1'b0;
        while (m8.size() > 3) step();
        wrreq = 1'b1;
        data  = 64'hC0DE;
        step();
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({empty_s[k], full_s[k], q_s[k]} !== exp_obs(k)) begin
                miscompares++;
                $display("FAIL rw_mid dut%0d: got %h want %h", k, {empty_s[k], full_s[k], q_s[k]}, exp_obs(k));
            end
        end
        wrreq = 1'b0;
        while (m8.size() > 0 || m4.size() > 0) step();
        wrreq = 1'b1;
        data  = 64'hD00D;
        step();
        wrreq = 1'b0;
        rdreq = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({empty_s[k], full_s[k], q_s[k]} !== {1'b0, 1'b0, 64'hD00D}) begin
                miscompares++;
                $display("FAIL rw_empty dut%0d: got %h want %h", k, {empty_s[k], full_s[k], q_s[k]}, {1'b0, 1'b0, 64'hD00D});
            end
        end
    endtask

    task automatic test_underflow();
        do_reset();
        rdreq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if ({empty_s[k], full_s[k], q_s[k]} !== {1'b1, 1'b0, 64'd0}) begin
                    miscompares++;
                    $display("FAIL underflow[%0d] dut%0d: got %h want %h", i, k, {empty_s[k], full_s[k], q_s[k]}, {1'b1, 1'b0, 64'd0});
                end
            end
        end
        rdreq = 1'b0;
        wrreq = 1'b1;
        data  = 64'h5A;
        step();
        data  = 64'h6B;
        step();
        wrreq = 1'b0;
        rdreq = 1'b1;
        step();
        rdreq = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({empty_s[k], full_s[k], q_s[k]} !== {1'b0, 1'b0, 64'h6B}) begin
                miscompares++;
                $display("FAIL after_underflow dut%0d: got %h want %h", k, {empty_s[k], full_s[k], q_s[k]}, {1'b0, 1'b0, 64'h6B});
            end
        end
    endtask

    task automatic test_random_wrap();
        logic [63:0] in_log  [$];
        logic [63:0] out_log [$];
        int nw = 0;
        int nr = 0;
        int cyc = 0;
        do_reset();
        while ((nw < 20 || nr < 20) && cyc < 500) begin
            wrreq = (nw < 20) && ($urandom_range(0, 1) == 1);
            rdreq = (nr < 20) && ($urandom_range(0, 1) == 1);
            data  = {$urandom, $urandom};
            if (wrreq && m4.size() < 4) begin
                nw++;
                in_log.push_back(data);
            end
            if (rdreq && m4.size() > 0) begin
                nr++;
                out_log.push_back(q_s[2]);
            end
            step();
            cyc++;
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if ({empty_s[k], full_s[k], q_s[k]} !== exp_obs(k)) begin
                    miscompares++;
                    $display("FAIL random[%0d] dut%0d: got %h want %h", cyc, k, {empty_s[k], full_s[k], q_s[k]}, exp_obs(k));
                end
            end
        end
        wrreq = 1'b0;
        rdreq = 1'b0;
        vectors++;
        if (cyc >= 500) begin
            miscompares++;
            $display("FAIL random_budget: got %0d writes %0d reads want 20 and 20", nw, nr);
        end
        for (int i = 0; i < out_log.size(); i++) begin
            vectors++;
            if (out_log[i] !== in_log[i]) begin
                miscompares++;
                $display("FAIL random_order[%0d]: got %h want %h", i, out_log[i], in_log[i]);
            end
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_fill_drain();
        test_show_ahead();
        test_simultaneous();
        test_underflow();
        test_random_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
